// File: rtl/parity_generator.sv
// ---------------------------------------------------------------------------
// parity_generator
//
// Registered parity generator for a wide data word. Every accepted word
// produces a whole-word even-parity bit, its odd-parity complement and one
// even-parity bit per byte. All outputs come straight from flops, with a
// latency of one cycle and a throughput of one word per cycle.
//
// Optional feature (macro PARITY_CHECK_EN): a checker that compares the
// generated whole-word even parity against a caller-supplied parity bit and
// flags a mismatch together with parityValid.
//
// Parameters:
//   DATA_WIDTH      input word width, a multiple of 8 and at least 8
//
// Ports:
//   clk             clock, all state updates on the rising edge
//   reset           synchronous active-high reset
//   dataValid       qualifies dataInput for this cycle
//   dataInput       word covered by parity
//   evenParity      XOR of all bits of the last accepted word
//   oddParity       inverse of evenParity
//   byteParity      bit i = XOR of byte i of the last accepted word
//   parityValid     one-cycle pulse per accepted word
//   expectedParity  (PARITY_CHECK_EN only) parity supplied with dataInput
//   parityError     (PARITY_CHECK_EN only) mismatch flag, 0 unless parityValid
// ---------------------------------------------------------------------------
module parity_generator #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    dataValid,
  input  logic [DATA_WIDTH-1:0]   dataInput,
  output logic                    evenParity,
  output logic                    oddParity,
  output logic [DATA_WIDTH/8-1:0] byteParity,
  output logic                    parityValid
`ifdef PARITY_CHECK_EN
  ,
  input  logic                    expectedParity,
  output logic                    parityError
`endif
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;

  // Reject illegal widths at elaboration rather than silently truncating.
  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_width
    $error("parity_generator: DATA_WIDTH must be a multiple of 8 and >= 8");
  end

  logic [NUM_BYTES-1:0] byte_parity_d, byte_parity_q;
  logic                 even_parity_d, even_parity_q;
  logic                 odd_parity_q;
  logic                 parity_valid_q;

  // Two-level tree: reduce each byte, then reduce the byte results. The
  // whole-word parity is thereby guaranteed to match the per-byte bits.
  // NOTE: every signal written in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    byte_parity_d = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      byte_parity_d[i] = ^dataInput[8*i +: 8];
    end
    even_parity_d = ^byte_parity_d;
  end

  // Parity registers load only on acceptance and otherwise hold; the valid
  // pulse follows dataValid every cycle so it lasts exactly one cycle per word.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_parity_q  <= '0;
      even_parity_q  <= 1'b0;
      odd_parity_q   <= 1'b1;
      parity_valid_q <= 1'b0;
    end else begin
      parity_valid_q <= dataValid;
      if (dataValid) begin
        byte_parity_q <= byte_parity_d;
        even_parity_q <= even_parity_d;
        odd_parity_q  <= ~even_parity_d;
      end
    end
  end

`ifdef PARITY_CHECK_EN
  logic parity_error_q;

  // Qualified by dataValid so the flag reads 0 whenever parityValid is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_error_q <= 1'b0;
    end else begin
      parity_error_q <= dataValid & (expectedParity != even_parity_d);
    end
  end

  assign parityError = parity_error_q;
`endif

  assign evenParity  = even_parity_q;
  assign oddParity   = odd_parity_q;
  assign byteParity  = byte_parity_q;
  assign parityValid = parity_valid_q;

endmodule

// File: tb/tb_parity_generator.sv
// ---------------------------------------------------------------------------
// tb_parity_generator
//
// Self-checking bench for parity_generator (DATA_WIDTH = 64). Expected values
// come from a reference model that counts ones per byte and per word, and
// tracks the last accepted word. Works with and without PARITY_CHECK_EN.
// ---------------------------------------------------------------------------
module tb_parity_generator;

  localparam int DW = 64;
  localparam int NB = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          dataValid;
  logic [DW-1:0] dataInput;
  logic          evenParity;
  logic          oddParity;
  logic [NB-1:0] byteParity;
  logic          parityValid;
  logic          expectedParity;
`ifdef PARITY_CHECK_EN
  logic          parityError;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference state: last accepted word and whether the previous edge accepted.
  logic [DW-1:0] ref_word;
  logic          ref_valid;
  logic          ref_error;

  always #5 clk = ~clk;

  parity_generator #(.DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .dataValid   (dataValid),
    .dataInput   (dataInput),
    .evenParity  (evenParity),
    .oddParity   (oddParity),
    .byteParity  (byteParity),
    .parityValid (parityValid)
`ifdef PARITY_CHECK_EN
    ,
    .expectedParity (expectedParity),
    .parityError    (parityError)
`endif
  );

  // ---------------- reference model ----------------
  function automatic logic model_even(input logic [DW-1:0] d);
    return 1'($countones(d) % 2);
  endfunction

  function automatic logic [NB-1:0] model_bytes(input logic [DW-1:0] d);
    logic [NB-1:0] r;
    logic [7:0]    b;
    r = '0;
    for (int i = 0; i < NB; i++) begin
      b    = d[8*i +: 8];
      r[i] = 1'($countones(b) % 2);
    end
    return r;
  endfunction

  // Packed view {even, odd, bytes, valid} of what the model predicts.
  function automatic logic [NB+2:0] model_outputs();
    return {model_even(ref_word), ~model_even(ref_word), model_bytes(ref_word), ref_valid};
  endfunction

  // Drive one cycle of stimulus, advance the model, sample #1 after the edge.
  task automatic step(input logic rst, input logic v, input logic [DW-1:0] d,
                      input logic ep);
    reset          = rst;
    dataValid      = v;
    dataInput      = d;
    expectedParity = ep;
    @(posedge clk);
    if (rst) begin
      ref_word  = '0;
      ref_valid = 1'b0;
      ref_error = 1'b0;
    end else begin
      ref_valid = v;
      ref_error = v && (ep != model_even(d));
      if (v) ref_word = d;
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    tests_run++;
    if ({evenParity, oddParity, byteParity, parityValid} !== {1'b0, 1'b1, 8'h00, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_values: got %b want %b",
               {evenParity, oddParity, byteParity, parityValid}, {1'b0, 1'b1, 8'h00, 1'b0});
    end
`ifdef PARITY_CHECK_EN
    tests_run++;
    if (parityError !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_error: got %b want 0", parityError);
    end
`endif
  endtask

  task automatic test_directed();
    logic [DW-1:0] words [3];
    words[0] = 64'h0000_0000_FFFF_FFFF;
    words[1] = 64'h0000_0000_0001_FFFF;
    words[2] = 64'h0000_0000_AAAA_0555;
    foreach (words[k]) begin
      step(1'b0, 1'b1, words[k], 1'b0);
      tests_run++;
      if ({evenParity, oddParity, byteParity, parityValid} !== model_outputs()) begin
        tests_failed++;
        $display("FAIL directed_%0d: got %b want %b", k,
                 {evenParity, oddParity, byteParity, parityValid}, model_outputs());
      end
      // Idle cycle: valid must drop after exactly one cycle, parity must hold.
      step(1'b0, 1'b0, ~words[k], 1'b0);
      tests_run++;
      if ({evenParity, oddParity, byteParity, parityValid} !== model_outputs()) begin
        tests_failed++;
        $display("FAIL directed_hold_%0d: got %b want %b", k,
                 {evenParity, oddParity, byteParity, parityValid}, model_outputs());
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] words [3];
    logic          exp_even [3];
    logic [NB-1:0] exp_bytes [3];
    words[0] = 64'h8000_0000_0000_0000;
    words[1] = 64'h0;
    words[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    exp_even  = '{1'b1, 1'b0, 1'b0};
    exp_bytes = '{8'h80, 8'h00, 8'h00};
    foreach (words[k]) begin
      step(1'b0, 1'b1, words[k], 1'b0);
      tests_run++;
      if ({evenParity, oddParity, byteParity, parityValid} !==
          {exp_even[k], ~exp_even[k], exp_bytes[k], 1'b1}) begin
        tests_failed++;
        $display("FAIL b2b_%0d: got %b want %b", k,
                 {evenParity, oddParity, byteParity, parityValid},
                 {exp_even[k], ~exp_even[k], exp_bytes[k], 1'b1});
      end
    end
    step(1'b1, 1'b0, '0, 1'b0);
    tests_run++;
    if ({evenParity, oddParity, byteParity, parityValid} !== {1'b0, 1'b1, 8'h00, 1'b0}) begin
      tests_failed++;
      $display("FAIL b2b_reset: got %b want %b",
               {evenParity, oddParity, byteParity, parityValid}, {1'b0, 1'b1, 8'h00, 1'b0});
    end
  endtask

  task automatic test_reset_wins();
    // Establish a nonzero result, then assert reset together with a valid word.
    step(1'b0, 1'b1, 64'h0000_0000_0000_0007, 1'b0);
    step(1'b1, 1'b1, 64'h0100_0000_0000_0001, 1'b0);
    tests_run++;
    if ({evenParity, oddParity, byteParity, parityValid} !== {1'b0, 1'b1, 8'h00, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_wins: got %b want %b",
               {evenParity, oddParity, byteParity, parityValid}, {1'b0, 1'b1, 8'h00, 1'b0});
    end
    // Acceptance resumes on the first edge after reset falls.
    step(1'b0, 1'b1, 64'h0000_0100_0000_0000, 1'b0);
    tests_run++;
    if ({evenParity, oddParity, byteParity, parityValid} !== model_outputs()) begin
      tests_failed++;
      $display("FAIL reset_resume: got %b want %b",
               {evenParity, oddParity, byteParity, parityValid}, model_outputs());
    end
  endtask

`ifdef PARITY_CHECK_EN
  task automatic test_checker();
    step(1'b0, 1'b1, 64'h0000_0000_0001_FFFF, 1'b1);
    tests_run++;
    if (parityError !== 1'b0) begin
      tests_failed++;
      $display("FAIL checker_match: got %b want 0", parityError);
    end
    step(1'b0, 1'b1, 64'h0000_0000_0001_FFFF, 1'b0);
    tests_run++;
    if (parityError !== 1'b1) begin
      tests_failed++;
      $display("FAIL checker_mismatch: got %b want 1", parityError);
    end
    step(1'b0, 1'b0, 64'h0000_0000_0001_FFFF, 1'b0);
    tests_run++;
    if ({parityError, parityValid} !== 2'b00) begin
      tests_failed++;
      $display("FAIL checker_idle: got %b want 00", {parityError, parityValid});
    end
  endtask
`endif

  task automatic test_random();
    logic [DW-1:0] d;
    logic          v;
    logic          ep;
    for (int n = 0; n < 300; n++) begin
      d  = {$urandom, $urandom};
      // Sprinkle sparse words so single-byte parities vary a lot.
      if ($urandom_range(3) == 0) d = d & {$urandom, $urandom} & {$urandom, $urandom};
      v  = ($urandom_range(9) < 7);
      ep = 1'($urandom_range(1));
      step(1'b0, v, d, ep);
      tests_run++;
      if ({evenParity, oddParity, byteParity, parityValid} !== model_outputs()) begin
        tests_failed++;
        $display("FAIL random_%0d: got %b want %b", n,
                 {evenParity, oddParity, byteParity, parityValid}, model_outputs());
      end
`ifdef PARITY_CHECK_EN
      tests_run++;
      if (parityError !== ref_error) begin
        tests_failed++;
        $display("FAIL random_error_%0d: got %b want %b", n, parityError, ref_error);
      end
`endif
    end
  endtask

  initial begin
    ref_word  = '0;
    ref_valid = 1'b0;
    ref_error = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_wins();
`ifdef PARITY_CHECK_EN
    test_checker();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
